// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// UART transmitter. A requester's byte is latched on grant and handed to the
// transmitter with a one-cycle tx_start. The completion is reported back with cmp.
// Optional feature: define UART_ARB_TIMEOUT_EN to add a watchdog that abandons
// a frame if tx_done does not arrive within TIMEOUT_CYCLES clocks.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FRAME_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             cmp,
    output logic                           tx_start,
    output logic [FRAME_WIDTH-1:0]         tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           active,
    output logic                           timeout_err
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [OW-1:0]          ptr;
    logic [OW-1:0]          sel;
    logic                   sel_valid;
    logic [FRAME_WIDTH-1:0] req_bytes [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
`endif

    // Split the flat request data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*FRAME_WIDTH +: FRAME_WIDTH];
        end
    end

    // Round-robin search: first set req bit starting just after the last owner.
    always_comb begin
        logic [OW-1:0] idx;
        idx       = '0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = OW'((int'(ptr) + k) % NUM_REQ);
            if (!sel_valid && req[idx]) begin
                sel       = idx;
                sel_valid = 1'b1;
            end
        end
    end

    // Arbitration FSM; every output is a register, pulses default back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            cmp      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            owner    <= '0;
            active   <= 1'b0;
            ptr      <= OW'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            gnt      <= '0;
            cmp      <= '0;
            tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (sel_valid && !tx_busy) begin
                        tx_data  <= req_bytes[sel];
                        owner    <= sel;
                        gnt      <= NUM_REQ'(1) << sel;
                        tx_start <= 1'b1;
                        active   <= 1'b1;
                        state    <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        cmp    <= NUM_REQ'(1) << owner;
                        ptr    <= owner;
                        active <= 1'b0;
                        state  <= IDLE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= owner;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_ARB_TIMEOUT_EN
    // Without the watchdog the error flag can never fire; TIMEOUT_CYCLES is
    // always positive, so this comparison is a constant 0.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scoreboard bench for uart_tx_arbiter.
// Build with UART_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 120000;
`endif

    typedef enum int { EV_GNT, EV_CMP, EV_TMO } ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [3:0] vec;
        logic [7:0] data;
        logic [1:0] idx;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  cmp;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic [1:0]  owner;
    logic        active;
    logic        timeout_err;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .FRAME_WIDTH    (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .cmp         (cmp),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .owner       (owner),
        .active      (active),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic busy, input logic done);
        req      = r;
        req_data = d;
        tx_busy  = busy;
        tx_done  = done;
    endtask

    task automatic pushExp(input ev_kind_t k, input logic [3:0] v, input logic [7:0] d, input logic [1:0] i);
        ev_t e;
        e.kind = k;
        e.vec  = v;
        e.data = d;
        e.idx  = i;
        exp_q.push_back(e);
    endtask

    task automatic waitGnt(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("gnt_within_budget", 32'(ok), 32'd1);
    endtask

    // Scoreboard monitor: every gnt/cmp/timeout pulse must match the next expectation.
    always @(negedge clk) begin
        ev_t e;
        if (rst && (gnt != 4'b0 || cmp != 4'b0 || timeout_err)) begin
            checkOutput("sb_onehot", 32'($onehot0(gnt) && $onehot0(cmp)), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL sb_unexpected: gnt=%b cmp=%b timeout_err=%b, expected no event", gnt, cmp, timeout_err);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    EV_GNT: begin
                        checkOutput("sb_gnt", 32'(gnt), 32'(e.vec));
                        checkOutput("sb_tx_start", 32'(tx_start), 32'd1);
                        checkOutput("sb_tx_data", 32'(tx_data), 32'(e.data));
                        checkOutput("sb_owner", 32'(owner), 32'(e.idx));
                        checkOutput("sb_active_set", 32'(active), 32'd1);
                    end
                    EV_CMP: begin
                        checkOutput("sb_cmp", 32'(cmp), 32'(e.vec));
                        checkOutput("sb_active_clr", 32'(active), 32'd0);
                    end
                    default: begin
                        checkOutput("sb_timeout", 32'(timeout_err), 32'd1);
                        checkOutput("sb_timeout_cmp", 32'(cmp), 32'd0);
                    end
                endcase
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        logic [31:0] data1, data2, data3, data5;
        logic [7:0]  rr_bytes [4];
        int          early;

        data1 = {8'h44, 8'hA5, 8'h22, 8'h11};
        data2 = {8'h40, 8'h30, 8'h20, 8'h10};
        data3 = {8'hD4, 8'hC3, 8'hB2, 8'h5A};
        data5 = {8'h93, 8'h77, 8'h66, 8'h39};
        rr_bytes[0] = 8'h10;
        rr_bytes[1] = 8'h20;
        rr_bytes[2] = 8'h30;
        rr_bytes[3] = 8'h40;

        rst = 1'b0;
        applyStimulus(4'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_cmp", 32'(cmp), 32'd0);
        checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single request from requester 2.
        $display("[TB] single request");
        pushExp(EV_GNT, 4'b0100, 8'hA5, 2'd2);
        applyStimulus(4'b0100, data1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_gnt", 32'(gnt), 32'h4);
        checkOutput("t1_tx_start", 32'(tx_start), 32'd1);
        checkOutput("t1_tx_data", 32'(tx_data), 32'hA5);
        checkOutput("t1_owner", 32'(owner), 32'd2);
        applyStimulus(4'b0, data1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_gnt_pulse", 32'(gnt), 32'd0);
        checkOutput("t1_start_pulse", 32'(tx_start), 32'd0);
        checkOutput("t1_active_held", 32'(active), 32'd1);
        pushExp(EV_CMP, 4'b0100, 8'h00, 2'd2);
        applyStimulus(4'b0, data1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1_cmp", 32'(cmp), 32'h4);
        checkOutput("t1_tx_data_stable", 32'(tx_data), 32'hA5);
        applyStimulus(4'b0, data1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_cmp_pulse", 32'(cmp), 32'd0);

        // tx_done while idle must not produce a completion.
        applyStimulus(4'b0, data1, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0, data1, 1'b0, 1'b0);
        checkOutput("idle_done_no_cmp", 32'(cmp), 32'd0);
        @(negedge clk);

        // All requesters active: grants rotate from requester 0.
        $display("[TB] round robin");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(4'b1111, data2, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++) begin
            pushExp(EV_GNT, 4'(1 << (f % 4)), rr_bytes[f % 4], 2'(f % 4));
            waitGnt(5);
            checkOutput("rr_owner", 32'(owner), 32'(f % 4));
            @(negedge clk);
            pushExp(EV_CMP, 4'(1 << (f % 4)), 8'h00, 2'(f % 4));
            applyStimulus(4'b1111, data2, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput("rr_cmp", 32'(cmp), 32'(1 << (f % 4)));
            applyStimulus((f == 4) ? 4'b0 : 4'b1111, data2, 1'b0, 1'b0);
        end
        @(negedge clk);

        // Busy transmitter blocks the grant.
        $display("[TB] busy transmitter");
        applyStimulus(4'b0001, data3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("busy_no_gnt", 32'(gnt), 32'd0);
        end
        pushExp(EV_GNT, 4'b0001, 8'h5A, 2'd0);
        applyStimulus(4'b0001, data3, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("busy_release_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0, data3, 1'b0, 1'b0);
        @(negedge clk);

        // tx_done and a new request together: one idle cycle before the grant.
        $display("[TB] done with pending request");
        pushExp(EV_CMP, 4'b0001, 8'h00, 2'd0);
        pushExp(EV_GNT, 4'b0010, 8'hB2, 2'd1);
        applyStimulus(4'b0010, data3, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("gap_cmp", 32'(cmp), 32'h1);
        checkOutput("gap_no_gnt", 32'(gnt), 32'd0);
        applyStimulus(4'b0010, data3, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("gap_gnt", 32'(gnt), 32'h2);
        checkOutput("gap_tx_data", 32'(tx_data), 32'hB2);
        applyStimulus(4'b0, data3, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during SEND clears everything at once and drops the frame.
        $display("[TB] reset in send");
        checkOutput("pre_rst_active", 32'(active), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_pulses", 32'({gnt, cmp, tx_start, timeout_err}), 32'd0);
        checkOutput("async_rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("async_rst_owner", 32'(owner), 32'd0);
        checkOutput("async_rst_active", 32'(active), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(4'b0, data5, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_abandon_no_cmp", 32'(cmp), 32'd0);
        pushExp(EV_GNT, 4'b0001, 8'h39, 2'd0);
        applyStimulus(4'b1001, data5, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0, data5, 1'b0, 1'b0);
        @(negedge clk);
        pushExp(EV_CMP, 4'b0001, 8'h00, 2'd0);
        applyStimulus(4'b0, data5, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0, data5, 1'b0, 1'b0);
        @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // Withheld tx_done: watchdog fires 50 cycles after tx_start.
        $display("[TB] timeout");
        pushExp(EV_GNT, 4'b0100, 8'h77, 2'd2);
        applyStimulus(4'b0100, data5, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("tmo_tx_start", 32'(tx_start), 32'd1);
        applyStimulus(4'b0, data5, 1'b0, 1'b0);
        early = 0;
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            if (timeout_err || !active) early++;
        end
        checkOutput("tmo_not_early", 32'(early), 32'd0);
        pushExp(EV_TMO, 4'b0, 8'h00, 2'd0);
        @(negedge clk);
        checkOutput("tmo_pulse", 32'(timeout_err), 32'd1);
        checkOutput("tmo_active_clr", 32'(active), 32'd0);
        checkOutput("tmo_no_cmp", 32'(cmp), 32'd0);
        @(negedge clk);
        checkOutput("tmo_one_cycle", 32'(timeout_err), 32'd0);
`else
        early = 0;
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter FRAME_WIDTH, default 8, giving the data bits per UART frame.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 120000, giving the maximum clk cycles to wait for tx_done (used only with UART_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester send request, held high until granted.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*FRAME_WIDTH bits: requester i's byte in bits [i*FRAME_WIDTH +: FRAME_WIDTH].
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot, one-cycle pulse when requester i's byte is accepted.
REQ-009 The block SHALL have port cmp, output, NUM_REQ bits: one-hot, one-cycle pulse when requester i's frame has finished transmitting.
REQ-010 The block SHALL have port tx_start, output, 1 bit: one-cycle start pulse to the shared UART transmitter.
REQ-011 The block SHALL have port tx_data, output, FRAME_WIDTH bits: latched byte presented to the transmitter.
REQ-012 The block SHALL have port tx_busy, input, 1 bit: transmitter busy.
REQ-013 The block SHALL have port tx_done, input, 1 bit: transmitter one-cycle frame-complete pulse.
REQ-014 The block SHALL have port owner, output, $clog2(NUM_REQ) bits: index of the current or last granted requester.
REQ-015 The block SHALL have port active, output, 1 bit: high while a granted frame is outstanding.
REQ-016 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when the transmitter fails to complete.

Function
REQ-017 The FSM SHALL have two states, IDLE and SEND, with all outputs registered.
REQ-018 In IDLE, when req != 0 and tx_busy = 0, the block SHALL select the first set req bit searching round-robin from index ptr+1 (modulo NUM_REQ).
REQ-019 On that selection edge the block SHALL latch the selected byte into tx_data, set owner, pulse gnt[sel] and tx_start together one cycle, set active = 1, and enter SEND.
REQ-020 Latency from req sampled high to gnt/tx_start SHALL be exactly 1 clk cycle.
REQ-021 tx_data SHALL remain stable from tx_start until the next grant.
REQ-022 In IDLE with tx_busy = 1, no grant SHALL be issued.
REQ-023 In SEND, on tx_done = 1, the block SHALL pulse cmp[owner] one cycle, set ptr = owner, clear active, and return to IDLE.
REQ-024 req changes and new requests arriving in SEND SHALL be ignored.
REQ-025 If tx_done and req arrive in the same cycle, the next grant SHALL occur no earlier than 1 cycle after the return to IDLE (minimum 1 IDLE cycle between frames).
REQ-026 tx_done arriving in IDLE SHALL be ignored, with no cmp pulse.
REQ-027 With all requesters continuously requesting, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0.
REQ-028 gnt and cmp SHALL never have more than one bit set.

Reset
REQ-029 While rst = 0 (asynchronous assert, synchronous release), the block SHALL force state = IDLE, gnt = 0, cmp = 0, tx_start = 0, tx_data = 0, owner = 0, active = 0, timeout_err = 0, and ptr = NUM_REQ-1, so requester 0 has first priority.
REQ-030 A reset in SEND SHALL abandon the frame without a cmp pulse.

Configuration
REQ-031 With macro UART_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to SEND and increment each SEND cycle; on reaching TIMEOUT_CYCLES without tx_done, the block SHALL pulse timeout_err one cycle, give no cmp pulse, set ptr = owner, clear active, and return to IDLE.
REQ-032 With macro UART_ARB_TIMEOUT_EN undefined, the counter SHALL be absent, timeout_err SHALL be tied 0, and SEND SHALL wait indefinitely.

Verification
REQ-033 The bench SHALL apply reset, then req = 4'b0100 with byte 8'hA5 -> next cycle gnt = 4'b0100, tx_start = 1, tx_data = 8'hA5, owner = 2; after tx_done -> cmp = 4'b0100.
REQ-034 The bench SHALL hold req = 4'b1111 for 5 frames -> grant order 0,1,2,3,0.
REQ-035 The bench SHALL hold tx_busy = 1 with req = 4'b0001 -> no gnt until tx_busy = 0, then gnt one cycle later.
REQ-036 The bench SHALL assert tx_done while req = 4'b0010 is pending -> one IDLE cycle, then gnt = 4'b0010.
REQ-037 The bench SHALL assert rst = 0 in SEND -> all outputs 0 immediately; after release, req = 4'b1001 -> gnt = 4'b0001.
REQ-038 With UART_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES = 50, the bench SHALL withhold tx_done -> timeout_err pulses 50 cycles after tx_start, no cmp pulse, active = 0.
